// File: rtl/note_pkg.sv
// Shared note definitions for the note decoder and the tone generator.
package note_pkg;

  localparam int unsigned NUM_NOTES = 7;

  typedef logic [2:0] note_t;

  localparam note_t NOTE_A    = 3'd0;
  localparam note_t NOTE_B    = 3'd1;
  localparam note_t NOTE_C    = 3'd2;
  localparam note_t NOTE_D    = 3'd3;
  localparam note_t NOTE_E    = 3'd4;
  localparam note_t NOTE_F    = 3'd5;
  localparam note_t NOTE_G    = 3'd6;
  localparam note_t NOTE_NONE = 3'd7;

  // A period is accepted when within NOM >> TOL_SHIFT (about 1.6 %) of nominal.
  localparam int unsigned TOL_SHIFT = 6;

  // Tone frequencies in Hz, indexed by note code.
  localparam int unsigned NOTE_FREQ_HZ [NUM_NOTES] = '{220, 247, 261, 294, 330, 349, 392};

  // Nominal periods at the reference 50 MHz clock (CLK_HZ / freq, truncated).
  localparam int unsigned NOM_PERIOD_50M [NUM_NOTES] =
    '{227272, 202429, 191570, 170068, 151515, 143266, 127551};

  // Nominal period in clk cycles for note n at clock rate clk_hz.
  function automatic logic [19:0] nom_period(input int unsigned clk_hz, input logic [2:0] n);
    return 20'(clk_hz / NOTE_FREQ_HZ[n]);
  endfunction

endpackage

// File: rtl/wave_edge_sync.sv
// Two-flop synchronizer for the asynchronous wave input plus rising-edge detect.
module wave_edge_sync (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic wave_i,
  output logic rise_o
);

  // [0],[1]: synchronizer; [2]: previous synchronized level for edge detect.
  logic [2:0] sync_q;

  // Shift the input through the synchronizer and history flop.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[1:0], wave_i};
    end
  end

  assign rise_o = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/note_decoder.sv
// Measures the period of a square-wave tone and commits it to a note code
// after CONFIRM consecutive matching classifications.
module note_decoder
  import note_pkg::*;
#(
  parameter int unsigned CLK_HZ  = 50000000,
  parameter int unsigned CONFIRM = 2,
  parameter int unsigned TIMEOUT = 262143
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wave_in,
  output logic [2:0]  note,
  output logic        note_valid,
  output logic        note_change,
  output logic [19:0] period,
  output logic [6:0]  led
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARMED = 2'd1;
  localparam logic [1:0] ST_TRACK = 2'd2;

  localparam logic [19:0] TIMEOUT_CNT = 20'(TIMEOUT);
  localparam logic [1:0]  CONFIRM_CNT = 2'(CONFIRM);

  localparam logic [19:0] NOM [NUM_NOTES] = '{
    nom_period(CLK_HZ, 3'd0), nom_period(CLK_HZ, 3'd1), nom_period(CLK_HZ, 3'd2),
    nom_period(CLK_HZ, 3'd3), nom_period(CLK_HZ, 3'd4), nom_period(CLK_HZ, 3'd5),
    nom_period(CLK_HZ, 3'd6)};

  function automatic logic within_tol(input logic [19:0] p, input logic [19:0] nom);
    logic [19:0] diff;
    diff = (p >= nom) ? (p - nom) : (nom - p);
    return diff <= (nom >> TOL_SHIFT);
  endfunction

  logic rise;

  wave_edge_sync u_sync (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .wave_i (wave_in),
    .rise_o (rise)
  );

  logic [1:0]  state_q, state_d;
  logic [19:0] cnt_q, cnt_d;
  logic [19:0] period_q, period_d;
  logic        cap_q, cap_d;
  logic        timeout;

  note_t       cls_q, cls_d;
  logic        cls_vld_q;

  note_t       last_cls_q, last_cls_d;
  logic [1:0]  match_q, match_d;
  note_t       note_q, note_d;
  logic        note_valid_q;
  logic        note_change_q;
  logic [6:0]  led_q, led_d;
  logic [7:0]  onehot;

  // Period measurement: edge/timeout handling and counter update.
  always_comb begin
    timeout  = (state_q != ST_IDLE) && (cnt_q == TIMEOUT_CNT);
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    cap_d    = 1'b0;
    if (rise) begin
      cnt_d = 20'd1;
      // An edge coinciding with timeout has no valid reference; it only re-arms.
      if (timeout || state_q == ST_IDLE) begin
        state_d = ST_ARMED;
      end else begin
        state_d  = ST_TRACK;
        period_d = cnt_q;
        cap_d    = 1'b1;
      end
    end else if (timeout) begin
      state_d = ST_IDLE;
    end else if (state_q != ST_IDLE && cnt_q != '1) begin
      cnt_d = cnt_q + 20'd1;
    end
  end

  // Measurement registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      period_q <= '0;
      cap_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      cap_q    <= cap_d;
    end
  end

  // Classify the captured period against each nominal window.
  always_comb begin
    cls_d = NOTE_NONE;
    for (int unsigned i = 0; i < NUM_NOTES; i++) begin
      if (within_tol(period_q, NOM[3'(i)])) begin
        cls_d = 3'(i);
      end
    end
  end

  // Classification register, one cycle after capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cls_q     <= NOTE_NONE;
      cls_vld_q <= 1'b0;
    end else begin
      cls_vld_q <= cap_q;
      if (cap_q) begin
        cls_q <= cls_d;
      end
    end
  end

  // Commit decision: count identical classifications, timeout forces none.
  always_comb begin
    match_d    = match_q;
    last_cls_d = last_cls_q;
    note_d     = note_q;
    if (timeout) begin
      match_d = '0;
      note_d  = NOTE_NONE;
    end else if (cls_vld_q) begin
      if (match_q != 2'd0 && cls_q == last_cls_q) begin
        match_d = (match_q == 2'd3) ? match_q : match_q + 2'd1;
      end else begin
        match_d    = 2'd1;
        last_cls_d = cls_q;
      end
      if (match_d >= CONFIRM_CNT) begin
        note_d = cls_q;
      end
    end
    // Code 7 shifts the set bit out of the low seven, giving an all-zero display.
    onehot = 8'd1 << note_d;
    led_d  = onehot[6:0];
  end

  // Committed note and its registered decodes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      match_q       <= '0;
      last_cls_q    <= NOTE_NONE;
      note_q        <= NOTE_NONE;
      note_valid_q  <= 1'b0;
      note_change_q <= 1'b0;
      led_q         <= '0;
    end else begin
      match_q       <= match_d;
      last_cls_q    <= last_cls_d;
      note_q        <= note_d;
      note_valid_q  <= (note_d != NOTE_NONE);
      note_change_q <= (note_d != note_q);
      led_q         <= led_d;
    end
  end

  assign note        = note_q;
  assign note_valid  = note_valid_q;
  assign note_change = note_change_q;
  assign period      = period_q;
  assign led         = led_q;

endmodule

// File: tb/tb_note_decoder.sv
// Self-checking bench for note_decoder with a scaled clock so tones stay short.
module tb_note_decoder;

  localparam int unsigned CLK_HZ  = 250000;
  localparam int unsigned CONFIRM = 2;
  localparam int unsigned TIMEOUT = 2000;
  localparam int unsigned FREQ [7] = '{220, 247, 261, 294, 330, 349, 392};

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        wave_in = 1'b0;
  logic [2:0]  note;
  logic        note_valid;
  logic        note_change;
  logic [19:0] period;
  logic [6:0]  led;

  note_decoder #(
    .CLK_HZ  (CLK_HZ),
    .CONFIRM (CONFIRM),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wave_in     (wave_in),
    .note        (note),
    .note_valid  (note_valid),
    .note_change (note_change),
    .period      (period),
    .led         (led)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // Reference model state, driven by the times at which rising edges take effect.
  bit m_armed;
  int m_last;
  int m_note;
  int m_match;
  int m_lastcls;
  bit m_chg;
  int m_period;
  int edge_q[$];
  int cmt_cyc_q[$];
  int cmt_cls_q[$];

  int chg_count;
  int chg_seen_cyc;
  int last_rise_cyc;

  task automatic check_eq(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", tag, cyc, act, exp);
    end
  endtask

  function automatic int nom(input int n);
    return int'(CLK_HZ / FREQ[n]);
  endfunction

  function automatic int classify(input int p);
    int d;
    for (int n = 0; n < 7; n++) begin
      d = p - nom(n);
      if (d < 0) d = -d;
      if (d <= nom(n) / 64) return n;
    end
    return 7;
  endfunction

  task automatic model_reset();
    m_armed = 0;
    m_last = 0;
    m_note = 7;
    m_match = 0;
    m_lastcls = 7;
    m_chg = 0;
    m_period = 0;
    edge_q.delete();
    cmt_cyc_q.delete();
    cmt_cls_q.delete();
  endtask

  task automatic model_step();
    int old_note;
    int cls;
    if (!rst_n) return;
    old_note = m_note;
    if (cmt_cyc_q.size() > 0 && cmt_cyc_q[0] == cyc) begin
      void'(cmt_cyc_q.pop_front());
      cls = cmt_cls_q.pop_front();
      if (m_match > 0 && cls == m_lastcls) begin
        m_match = (m_match < 3) ? m_match + 1 : 3;
      end else begin
        m_match = 1;
        m_lastcls = cls;
      end
      if (m_match >= int'(CONFIRM)) m_note = cls;
    end
    if (m_armed && (cyc - m_last == int'(TIMEOUT))) begin
      m_armed = 0;
      m_note = 7;
      m_match = 0;
    end
    if (edge_q.size() > 0 && edge_q[0] == cyc) begin
      void'(edge_q.pop_front());
      if (m_armed) begin
        m_period = cyc - m_last;
        cmt_cyc_q.push_back(cyc + 2);
        cmt_cls_q.push_back(classify(m_period));
      end
      m_armed = 1;
      m_last = cyc;
    end
    m_chg = (m_note != old_note);
  endtask

  task automatic compare_outputs();
    int exp_led;
    int exp_out;
    exp_led = (m_note < 7) ? (1 << m_note) : 0;
    exp_out = (m_note << 9) | (int'(m_note != 7) << 8) | (int'(m_chg) << 7) | exp_led;
    check_eq("out{note,valid,change,led}", int'({note, note_valid, note_change, led}), exp_out);
    check_eq("period", int'(period), m_period);
    if (note_change) begin
      chg_count++;
      chg_seen_cyc = cyc;
    end
  endtask

  // One clock: model reacts to the edge, outputs are compared at the falling edge.
  task automatic tick();
    @(posedge clk);
    cyc++;
    model_step();
    @(negedge clk);
    compare_outputs();
  endtask

  // n rising edges spaced p cycles apart; the wave ends low.
  task automatic run_wave(input int p, input int n);
    repeat (n) begin
      wave_in = 1'b1;
      edge_q.push_back(cyc + 3);
      last_rise_cyc = cyc;
      repeat (p / 2) tick();
      wave_in = 1'b0;
      repeat (p - p / 2) tick();
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_note"}, int'(note), 7);
    check_eq({tag, "_valid"}, int'(note_valid), 0);
    check_eq({tag, "_change"}, int'(note_change), 0);
    check_eq({tag, "_period"}, int'(period), 0);
    check_eq({tag, "_led"}, int'(led), 0);
  endtask

  initial begin
    int idx;
    int p;
    int reps;
    int tol;

    model_reset();
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (10) tick();

    // A locks on the third edge.
    chg_count = 0;
    run_wave(nom(0), 4);
    check_eq("A_note", int'(note), 0);
    check_eq("A_led", int'(led), 7'b0000001);
    check_eq("A_changes", chg_count, 1);

    // G then E, each committing after two matching periods.
    chg_count = 0;
    run_wave(nom(6), 3);
    check_eq("G_note", int'(note), 6);
    check_eq("G_period", int'(period), nom(6));
    check_eq("G_changes", chg_count, 1);
    chg_count = 0;
    run_wave(nom(4), 3);
    check_eq("E_note", int'(note), 4);
    check_eq("E_period", int'(period), nom(4));
    check_eq("E_changes", chg_count, 1);

    // Period between D and E classifies as none.
    chg_count = 0;
    run_wave(800, 3);
    check_eq("gap_note", int'(note), 7);
    check_eq("gap_changes", chg_count, 1);

    // Alternating A/B never commits.
    chg_count = 0;
    repeat (3) begin
      run_wave(nom(0), 1);
      run_wave(nom(1), 1);
    end
    check_eq("alt_note", int'(note), 7);
    check_eq("alt_changes", chg_count, 0);

    // Lock G, then stop the wave and wait for the timeout.
    run_wave(nom(6), 3);
    check_eq("G2_note", int'(note), 6);
    chg_count = 0;
    chg_seen_cyc = -1;
    repeat (TIMEOUT + 20) tick();
    check_eq("timeout_note", int'(note), 7);
    check_eq("timeout_led", int'(led), 0);
    check_eq("timeout_changes", chg_count, 1);
    check_eq("timeout_latency", chg_seen_cyc - last_rise_cyc, int'(TIMEOUT) + 3);

    // Edge landing exactly on the timeout only re-arms; one cycle less is measured.
    run_wave(TIMEOUT, 2);
    check_eq("to_edge_period", int'(period), nom(6));
    run_wave(TIMEOUT - 1, 2);
    check_eq("pre_to_period", int'(period), int'(TIMEOUT) - 1);

    // Lock F, reset mid-period, relock.
    run_wave(nom(5), 3);
    check_eq("F_note", int'(note), 5);
    wave_in = 1'b1;
    edge_q.push_back(cyc + 3);
    repeat (nom(5) / 2) tick();
    wave_in = 1'b0;
    repeat (100) tick();
    rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_outputs("midreset");
    repeat (3) tick();
    rst_n = 1'b1;
    repeat (200) tick();
    chg_count = 0;
    run_wave(nom(5), 4);
    check_eq("F_relock_note", int'(note), 5);
    check_eq("F_relock_changes", chg_count, 1);

    // Random tones with jitter inside the tolerance, plus arbitrary periods.
    repeat (12) begin
      idx = $urandom_range(0, 7);
      reps = $urandom_range(1, 3);
      repeat (reps) begin
        if (idx < 7) begin
          tol = nom(idx) / 64;
          p = nom(idx) + int'($urandom_range(0, tol)) - tol / 2;
        end else begin
          p = $urandom_range(600, 1300);
        end
        run_wave(p, 1);
      end
    end
    repeat (TIMEOUT + 10) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
